// File: rtl/pio_pkg.sv
// Shared register-map and parameter encodings for the PIO input block.
package pio_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,
        ADDR_RSVD = 2'd1,
        ADDR_MASK = 2'd2,
        ADDR_EDGE = 2'd3
    } pio_addr_e;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/pio_sync.sv
// Multi-stage flip-flop synchronizer for asynchronous input bits.
module pio_sync #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] async_data,
    output logic [WIDTH-1:0] sync_data
);

    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= async_data;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign sync_data = stages[DEPTH-1];

endmodule

// File: rtl/pio_in_edge_irq.sv
// PIO input port with edge capture, interrupt mask and registered bus reads.
module pio_in_edge_irq
    import pio_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int EDGE_TYPE   = 0,
    parameter int IRQ_MODE    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [31:0]           readdata,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] data_sync;
    logic [DATA_WIDTH-1:0] data_prev;
    logic [DATA_WIDTH-1:0] edge_det;
    logic [DATA_WIDTH-1:0] irqmask;
    logic [DATA_WIDTH-1:0] edgecapture;
    logic [DATA_WIDTH-1:0] capture_clear;
    logic [31:0]           readdata_next;
    logic                  irq_next;
    logic                  wr;
    logic                  unused_wdata;

    assign unused_wdata = &{1'b0, writedata};

    pio_sync #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .async_data (in_port),
        .sync_data  (data_sync)
    );

    generate
        if (EDGE_TYPE == EDGE_FALL) begin : g_fall
            assign edge_det = ~data_sync & data_prev;
        end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
            assign edge_det = data_sync ^ data_prev;
        end else begin : g_rise
            assign edge_det = data_sync & ~data_prev;
        end

        if (IRQ_MODE == IRQ_LEVEL) begin : g_irq_level
            assign irq_next = |(data_sync & irqmask);
        end else begin : g_irq_edge
            assign irq_next = |(edgecapture & irqmask);
        end
    endgenerate

    always_comb begin
        wr            = chipselect && !write_n;
        capture_clear = '0;
        if (wr && pio_addr_e'(address) == ADDR_EDGE) begin
            capture_clear = writedata[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        readdata_next = '0;
        case (pio_addr_e'(address))
            ADDR_DATA: readdata_next[DATA_WIDTH-1:0] = data_sync;
            ADDR_MASK: readdata_next[DATA_WIDTH-1:0] = irqmask;
            ADDR_EDGE: readdata_next[DATA_WIDTH-1:0] = edgecapture;
            default:   readdata_next = '0;
        endcase
    end

    // A new edge is OR-ed in after the clear so that set wins over clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_prev   <= '0;
            irqmask     <= '0;
            edgecapture <= '0;
            readdata    <= '0;
            irq         <= 1'b0;
        end else begin
            data_prev   <= data_sync;
            edgecapture <= (edgecapture & ~capture_clear) | edge_det;
            readdata    <= readdata_next;
            irq         <= irq_next;
            if (wr && pio_addr_e'(address) == ADDR_MASK) begin
                irqmask <= writedata[DATA_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Bench for pio_in_edge_irq: two parameterisations driven in lockstep against a history-based model.
module tb_pio_in_edge_irq;

    localparam int W = 8;
    localparam int S = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   rd_a, rd_b;
    logic          irq_a, irq_b;

    always #5 clk = ~clk;

    pio_in_edge_irq #(.DATA_WIDTH(W), .EDGE_TYPE(0), .IRQ_MODE(1), .SYNC_STAGES(S)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_a), .irq(irq_a)
    );

    pio_in_edge_irq #(.DATA_WIDTH(W), .EDGE_TYPE(2), .IRQ_MODE(0), .SYNC_STAGES(S)) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_b), .irq(irq_b)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: hist[0] is the newest in_port sample; the synchronized view lags by S-1 samples.
    logic [W-1:0] hist [S+1];
    logic [W-1:0] m_mask;
    logic [W-1:0] m_cap [2];
    logic [31:0]  m_rd  [2];
    logic         m_irq [2];
    int           m_edge_type [2] = '{0, 2};
    int           m_irq_mode  [2] = '{1, 0};

    function automatic logic [W-1:0] edges_of(input int et, input logic [W-1:0] cur, input logic [W-1:0] prev);
        case (et)
            0:       return cur & ~prev;
            1:       return ~cur & prev;
            default: return cur ^ prev;
        endcase
    endfunction

    task automatic model_reset();
        for (int j = 0; j <= S; j++) hist[j] = '0;
        m_mask = '0;
        for (int i = 0; i < 2; i++) begin
            m_cap[i] = '0;
            m_rd[i]  = '0;
            m_irq[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        logic [W-1:0] sync_v, prev_v, clr, edges;
        logic         wr;
        sync_v = hist[S-1];
        prev_v = hist[S];
        wr     = chipselect && !write_n;
        clr    = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
        for (int i = 0; i < 2; i++) begin
            case (address)
                2'd0:    m_rd[i] = 32'(sync_v);
                2'd2:    m_rd[i] = 32'(m_mask);
                2'd3:    m_rd[i] = 32'(m_cap[i]);
                default: m_rd[i] = 32'd0;
            endcase
            m_irq[i] = (m_irq_mode[i] == 1) ? |(m_cap[i] & m_mask) : |(sync_v & m_mask);
            edges    = edges_of(m_edge_type[i], sync_v, prev_v);
            m_cap[i] = (m_cap[i] & ~clr) | edges;
        end
        if (wr && address == 2'd2) m_mask = writedata[W-1:0];
        for (int j = S; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = in_port;
    endtask

    task automatic step();
        if (reset_n) model_step();
        @(posedge clk);
        #1;
        check("rd_a",  rd_a,  m_rd[0]);
        check("irq_a", 32'(irq_a), 32'(m_irq[0]));
        check("rd_b",  rd_b,  m_rd[1]);
        check("irq_b", 32'(irq_b), 32'(m_irq[1]));
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        address    = addr;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = data;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = $urandom;
    endtask

    task automatic read(input logic [1:0] addr);
        address = addr;
        step();
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        model_reset();
        steps(3);
        check("reset rd_a", rd_a, 32'd0);
        check("reset irq_a", 32'(irq_a), 32'd0);
        reset_n = 1'b1;
        steps(3);

        // Data register read-back and reserved address.
        in_port = 8'hA5;
        address = 2'd0;
        steps(3);
        check("data A5 a", rd_a, 32'h0000_00A5);
        check("data A5 b", rd_b, 32'h0000_00A5);
        read(2'd1);
        check("reserved reads 0", rd_a, 32'd0);
        bus_write(2'd0, 32'hFFFF_FFFF);
        bus_write(2'd1, 32'hFFFF_FFFF);
        read(2'd0);
        check("data write ignored", rd_a, 32'h0000_00A5);

        // Rising-edge capture latency and write-1-to-clear.
        in_port = 8'h00;
        steps(4);
        bus_write(2'd3, 32'hFF);
        bus_write(2'd2, 32'h01);
        in_port = 8'h03;
        step();
        in_port = 8'h00;
        step();
        step();
        check("irq not yet", 32'(irq_a), 32'd0);
        step();
        check("irq at k+3", 32'(irq_a), 32'd1);
        read(2'd3);
        check("capture 03", rd_a, 32'h03);
        bus_write(2'd3, 32'h01);
        read(2'd3);
        check("capture after clear", rd_a, 32'h02);
        check("irq after clear", 32'(irq_a), 32'd0);

        // Edge arriving in the same cycle as its clear keeps the bit set.
        bus_write(2'd3, 32'hFF);
        steps(2);
        in_port = 8'h01;
        steps(2);
        bus_write(2'd3, 32'h01);
        read(2'd3);
        check("set wins", rd_a & 32'h1, 32'h1);
        in_port = 8'h00;
        steps(4);

        // Any-edge capture on bit 7 (dut_b).
        bus_write(2'd3, 32'hFF);
        in_port = 8'h80;
        steps(3);
        read(2'd3);
        check("any rise b7", rd_b & 32'h80, 32'h80);
        bus_write(2'd3, 32'h80);
        read(2'd3);
        check("any cleared b7", rd_b & 32'h80, 32'h0);
        in_port = 8'h00;
        steps(3);
        read(2'd3);
        check("any fall b7", rd_b & 32'h80, 32'h80);

        // Level-mode interrupt (dut_b).
        bus_write(2'd2, 32'h80);
        in_port = 8'h80;
        steps(3);
        check("level irq on", 32'(irq_b), 32'd1);
        bus_write(2'd2, 32'h00);
        step();
        check("level irq masked", 32'(irq_b), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) != 0) in_port = W'($urandom);
            address    = 2'($urandom_range(0, 3));
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            writedata  = $urandom;
            step();
        end
        chipselect = 1'b0;
        write_n    = 1'b1;

        // Mid-operation reset discards a full capture register.
        in_port = 8'h00;
        steps(3);
        bus_write(2'd3, 32'hFF);
        bus_write(2'd2, 32'hFF);
        in_port = 8'hFF;
        steps(3);
        read(2'd3);
        check("capture FF", rd_a, 32'hFF);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async reset rd_a", rd_a, 32'd0);
        check("async reset irq_a", 32'(irq_a), 32'd0);
        check("async reset rd_b", rd_b, 32'd0);
        check("async reset irq_b", 32'(irq_b), 32'd0);
        steps(2);
        reset_n = 1'b1;
        address = 2'd3;
        steps(2);
        check("no capture after release", rd_a, 32'd0);
        read(2'd2);
        check("mask cleared by reset", rd_a, 32'd0);
        steps(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pio_in_edge_irq.md
PIO_IN_EDGE_IRQ -- requirements
Module: pio_in_edge_irq

Interface
REQ-001 Parameter DATA_WIDTH, default 8: input port width; legal range 1..32.
REQ-002 Parameter EDGE_TYPE, default 0: edge that sets a capture bit; 0=rising, 1=falling, 2=any.
REQ-003 Parameter IRQ_MODE, default 1: interrupt source; 0=level (synchronized data), 1=edge (capture register).
REQ-004 Parameter SYNC_STAGES, default 2: synchronizer depth on in_port; legal range 2..3.
REQ-005 Port clk, input, 1: clock; all state updates on its rising edge.
REQ-006 Port reset_n, input, 1: reset, asynchronous, active-low.
REQ-007 Port address, input, 2: register select.
REQ-008 Port chipselect, input, 1: bus access qualifier for writes.
REQ-009 Port write_n, input, 1: active-low write strobe.
REQ-010 Port writedata, input, 32: write data.
REQ-011 Port in_port, input, DATA_WIDTH: asynchronous external inputs.
REQ-012 Port readdata, output, 32: registered read data.
REQ-013 Port irq, output, 1: registered interrupt request, active-high.

Function
REQ-014 in_port SHALL pass through a SYNC_STAGES flip-flop chain per bit; the last stage is data_sync.
REQ-015 data_sync SHALL be delayed one further cycle into data_prev for edge detection.
REQ-016 Edge detect: rising = data_sync & ~data_prev; falling = ~data_sync & data_prev; any = XOR; selected by EDGE_TYPE.
REQ-017 Register map: 0 data (RO, data_sync), 1 reserved (reads 0), 2 irqmask (RW, DATA_WIDTH bits), 3 edgecapture (read; write-1-to-clear).
REQ-018 A write occurs when chipselect=1 and write_n=0; writes to addresses 0 and 1 SHALL be ignored.
REQ-019 The irqmask write SHALL load writedata[DATA_WIDTH-1:0].
REQ-020 Each edgecapture bit SHALL set on a detected edge and remain set until cleared by writing 1 to that bit at address 3.
REQ-021 A simultaneous edge and clear on the same bit SHALL leave the bit set (set wins).
REQ-022 readdata SHALL be registered every cycle from the addressed register (one-cycle read latency, no clock-enable gating); bits above DATA_WIDTH read 0.
REQ-023 irq SHALL be registered: IRQ_MODE=1: irq <= |(edgecapture & irqmask); IRQ_MODE=0: irq <= |(data_sync & irqmask).
REQ-024 Latency: an in_port change sampled at edge k SHALL appear in data_sync at edge k+SYNC_STAGES-1, in edgecapture one edge later, and on irq one further edge later.
REQ-025 Clearing the last unmasked pending bit SHALL deassert irq on the edge following the clear.
REQ-026 Changing irqmask SHALL affect irq on the edge after the write; captured bits are unaffected by the mask.

Reset
REQ-027 While reset_n=0: synchronizer, data_prev, irqmask, edgecapture, readdata and irq SHALL be 0.
REQ-028 The first cycle after reset release SHALL not report a spurious edge, because data_prev and data_sync reset equal.
REQ-029 Assertion of reset mid-operation SHALL discard all pending captures immediately.

Structure
REQ-030 Shared package pio_pkg SHALL hold the address constants (ADDR_DATA=0, ADDR_MASK=2, ADDR_EDGE=3) and the EDGE_RISE/EDGE_FALL/EDGE_ANY and IRQ_LEVEL/IRQ_EDGE encodings.
REQ-031 A single sub-module pio_sync (parametrised width and depth, async active-low reset) SHALL implement the synchronizer.

Verification
REQ-032 DATA_WIDTH=8, SYNC_STAGES=2: drive in_port 0x00->0xA5 -> read address 0 returns 0x000000A5; address 1 returns 0.
REQ-033 EDGE_TYPE=0: in_port 0x00->0x03->0x00, mask=0x01 -> edgecapture=0x03, irq=1 exactly 3 edges after sampling; write 0x01 to address 3 -> edgecapture=0x02, irq=0.
REQ-034 Rising edge on bit 0 in the same cycle as a clear of bit 0 -> edgecapture bit 0 remains 1.
REQ-035 EDGE_TYPE=2: toggle bit 7 high then low with clears between -> capture set on both transitions.
REQ-036 IRQ_MODE=0, mask=0x80: in_port[7]=1 -> irq=1; mask=0x00 -> irq=0 on the next edge.
REQ-037 Pulse reset_n low with edgecapture=0xFF -> all registers and irq read 0, and no capture occurs on the first cycle after release.
